// File: rtl/argmax_stream.sv
// Streaming argmax: folds LANES class scores per beat into running best/runner-up
// registers and presents the winner, runner-up and margin once per frame.
`timescale 1ns/1ps
module argmax_stream #(
    parameter int DATA_WIDTH  = 29,
    parameter int NUM_CLASSES = 10,
    parameter int LANES       = 2,
    parameter int SIGNED      = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*DATA_WIDTH-1:0]   in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [31:0]                   predict,
    output logic [31:0]                   second,
    output logic [DATA_WIDTH-1:0]         max_val,
    output logic [DATA_WIDTH:0]           margin
);

    localparam int BEATS = (NUM_CLASSES + LANES - 1) / LANES;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int IDX_W = $clog2(BEATS * LANES + 1);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       beat_cnt;
    logic                   accept, last_beat, first_beat;

    logic [DATA_WIDTH-1:0]  run_best_val, run_sec_val;
    logic [IDX_W-1:0]       run_best_idx, run_sec_idx;
    logic                   run_sec_vld;

    logic [DATA_WIDTH-1:0]  beat_best_val, beat_sec_val;
    logic [IDX_W-1:0]       beat_best_idx, beat_sec_idx;
    logic                   beat_best_vld, beat_sec_vld;

    logic [DATA_WIDTH-1:0]  new_best_val, new_sec_val;
    logic [IDX_W-1:0]       new_best_idx, new_sec_idx;
    logic                   new_sec_vld;
    logic [DATA_WIDTH:0]    new_margin;

    function automatic logic gt(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
        if (SIGNED != 0) return $signed(a) > $signed(b);
        return a > b;
    endfunction

    function automatic logic [DATA_WIDTH:0] ext(input logic [DATA_WIDTH-1:0] a);
        if (SIGNED != 0) return {a[DATA_WIDTH-1], a};
        return {1'b0, a};
    endfunction

    assign accept     = in_valid && in_ready && !clear;
    assign last_beat  = (beat_cnt == CNT_W'(BEATS - 1));
    assign first_beat = (beat_cnt == '0);

    // Lanes are visited in class order, so only a strictly greater score may
    // displace an earlier one; that is what makes ties favour the lower index.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        beat_best_val = '0;
        beat_best_idx = '0;
        beat_best_vld = 1'b0;
        beat_sec_val  = '0;
        beat_sec_idx  = '0;
        beat_sec_vld  = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            if (int'(beat_cnt) * LANES + k < NUM_CLASSES) begin
                if (!beat_best_vld || gt(in_data[k*DATA_WIDTH +: DATA_WIDTH], beat_best_val)) begin
                    beat_sec_val  = beat_best_val;
                    beat_sec_idx  = beat_best_idx;
                    beat_sec_vld  = beat_best_vld;
                    beat_best_val = in_data[k*DATA_WIDTH +: DATA_WIDTH];
                    beat_best_idx = IDX_W'(int'(beat_cnt) * LANES + k);
                    beat_best_vld = 1'b1;
                end else if (!beat_sec_vld || gt(in_data[k*DATA_WIDTH +: DATA_WIDTH], beat_sec_val)) begin
                    beat_sec_val  = in_data[k*DATA_WIDTH +: DATA_WIDTH];
                    beat_sec_idx  = IDX_W'(int'(beat_cnt) * LANES + k);
                    beat_sec_vld  = 1'b1;
                end
            end
        end
    end

    // Running entries always carry lower class indices than the current beat.
    always_comb begin
        new_best_val = run_best_val;
        new_best_idx = run_best_idx;
        new_sec_val  = run_sec_val;
        new_sec_idx  = run_sec_idx;
        new_sec_vld  = run_sec_vld;
        if (first_beat) begin
            new_best_val = beat_best_val;
            new_best_idx = beat_best_idx;
            new_sec_val  = beat_sec_val;
            new_sec_idx  = beat_sec_idx;
            new_sec_vld  = beat_sec_vld;
        end else if (gt(beat_best_val, run_best_val)) begin
            new_best_val = beat_best_val;
            new_best_idx = beat_best_idx;
            new_sec_vld  = 1'b1;
            if (beat_sec_vld && gt(beat_sec_val, run_best_val)) begin
                new_sec_val = beat_sec_val;
                new_sec_idx = beat_sec_idx;
            end else begin
                new_sec_val = run_best_val;
                new_sec_idx = run_best_idx;
            end
        end else if (!run_sec_vld || gt(beat_best_val, run_sec_val)) begin
            new_sec_val = beat_best_val;
            new_sec_idx = beat_best_idx;
            new_sec_vld = 1'b1;
        end
        new_margin = ext(new_best_val) - ext(new_sec_val);
    end

    always_comb begin
        state_nxt = state;
        in_ready  = (state == ACCUM);
        out_valid = (state == HOLD);
        if (clear) begin
            state_nxt = ACCUM;
        end else begin
            case (state)
                ACCUM:   if (accept && last_beat) state_nxt = HOLD;
                HOLD:    if (out_ready)           state_nxt = ACCUM;
                default: state_nxt = ACCUM;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ACCUM;
            beat_cnt     <= '0;
            run_best_val <= '0;
            run_best_idx <= '0;
            run_sec_val  <= '0;
            run_sec_idx  <= '0;
            run_sec_vld  <= 1'b0;
            predict      <= '0;
            second       <= '0;
            max_val      <= '0;
            margin       <= '0;
        end else begin
            state <= state_nxt;
            if (clear) begin
                beat_cnt <= '0;
            end else if (accept) begin
                beat_cnt     <= last_beat ? '0 : beat_cnt + 1'b1;
                run_best_val <= new_best_val;
                run_best_idx <= new_best_idx;
                run_sec_val  <= new_sec_val;
                run_sec_idx  <= new_sec_idx;
                run_sec_vld  <= new_sec_vld;
                if (last_beat) begin
                    predict <= 32'(new_best_idx);
                    second  <= 32'(new_sec_idx);
                    max_val <= new_best_val;
                    margin  <= new_margin;
                end
            end
        end
    end

endmodule

// File: tb/tb_argmax_stream.sv
// Directed bench for argmax_stream: default configuration plus padded, two-class
// and single-lane variants, covering ties, extremes, backpressure and aborts.
`timescale 1ns/1ps
module tb_argmax_stream;

    localparam int DW = 29;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clear = 1'b0;
    logic out_ready = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    // a: defaults (10 classes, 2 lanes)
    logic              in_valid_a = 1'b0;
    logic [2*DW-1:0]   in_data_a = '0;
    logic              in_ready_a, out_valid_a;
    logic [31:0]       predict_a, second_a;
    logic [DW-1:0]     max_val_a;
    logic [DW:0]       margin_a;

    // b: 5 classes, 2 lanes (padded last beat)
    logic              in_valid_b = 1'b0;
    logic [2*DW-1:0]   in_data_b = '0;
    logic              in_ready_b, out_valid_b;
    logic [31:0]       predict_b, second_b;
    logic [DW-1:0]     max_val_b;
    logic [DW:0]       margin_b;

    // c: 2 classes, 2 lanes (single-beat frame)
    logic              in_valid_c = 1'b0;
    logic [2*DW-1:0]   in_data_c = '0;
    logic              in_ready_c, out_valid_c;
    logic [31:0]       predict_c, second_c;
    logic [DW-1:0]     max_val_c;
    logic [DW:0]       margin_c;

    // d: 3 classes, 1 lane
    logic              in_valid_d = 1'b0;
    logic [DW-1:0]     in_data_d = '0;
    logic              in_ready_d, out_valid_d;
    logic [31:0]       predict_d, second_d;
    logic [DW-1:0]     max_val_d;
    logic [DW:0]       margin_d;

    argmax_stream u_dut_a (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_data(in_data_a), .out_valid(out_valid_a), .out_ready(out_ready),
        .predict(predict_a), .second(second_a), .max_val(max_val_a), .margin(margin_a));

    argmax_stream #(.NUM_CLASSES(5)) u_dut_b (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_data(in_data_b), .out_valid(out_valid_b), .out_ready(out_ready),
        .predict(predict_b), .second(second_b), .max_val(max_val_b), .margin(margin_b));

    argmax_stream #(.NUM_CLASSES(2)) u_dut_c (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid_c), .in_ready(in_ready_c),
        .in_data(in_data_c), .out_valid(out_valid_c), .out_ready(out_ready),
        .predict(predict_c), .second(second_c), .max_val(max_val_c), .margin(margin_c));

    argmax_stream #(.NUM_CLASSES(3), .LANES(1)) u_dut_d (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid_d), .in_ready(in_ready_d),
        .in_data(in_data_d), .out_valid(out_valid_d), .out_ready(out_ready),
        .predict(predict_d), .second(second_d), .max_val(max_val_d), .margin(margin_d));

    int basic_s[10];
    int ties_s[10];
    int neg_s[10];
    int ext_s[10];
    int next_s[10];

    task automatic beat_a(input int s0, input int s1);
        in_valid_a = 1'b1;
        in_data_a  = {DW'(s1), DW'(s0)};
        @(posedge clk); #1;
        in_valid_a = 1'b0;
    endtask

    task automatic frame_a(input int s[10]);
        for (int i = 0; i < 10; i += 2) beat_a(s[i], s[i+1]);
    endtask

    task automatic consume;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        #12;
        checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid_a); end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready_a); end
        checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL reset_out_valid_after: got %b want 0", out_valid_a); end
        checks++; if (predict_a !== 32'd0 || second_a !== 32'd0) begin errors++; $display("FAIL reset_idx: got %0d/%0d want 0/0", predict_a, second_a); end
        checks++; if (max_val_a !== '0 || margin_a !== '0) begin errors++; $display("FAIL reset_vals: got %0h/%0h want 0/0", max_val_a, margin_a); end
    endtask

    task automatic test_basic;
        for (int i = 0; i < 8; i += 2) beat_a(basic_s[i], basic_s[i+1]);
        checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b want 0", out_valid_a); end
        beat_a(basic_s[8], basic_s[9]);
        checks++; if (out_valid_a !== 1'b1) begin errors++; $display("FAIL basic_out_valid: got %b want 1", out_valid_a); end
        checks++; if (in_ready_a !== 1'b0) begin errors++; $display("FAIL basic_in_ready_hold: got %b want 0", in_ready_a); end
        checks++; if (predict_a !== 32'd2) begin errors++; $display("FAIL basic_predict: got %0d want 2", predict_a); end
        checks++; if (second_a !== 32'd4) begin errors++; $display("FAIL basic_second: got %0d want 4", second_a); end
        checks++; if (max_val_a !== DW'(100)) begin errors++; $display("FAIL basic_max_val: got %0h want 64", max_val_a); end
        checks++; if (margin_a !== 30'd0) begin errors++; $display("FAIL basic_margin: got %0h want 0", margin_a); end
        consume();
        checks++; if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin errors++; $display("FAIL basic_release: got valid=%b ready=%b want 0/1", out_valid_a, in_ready_a); end
    endtask

    task automatic test_ties;
        frame_a(ties_s);
        checks++; if (predict_a !== 32'd0 || second_a !== 32'd1) begin errors++; $display("FAIL ties_idx: got %0d/%0d want 0/1", predict_a, second_a); end
        checks++; if (max_val_a !== 29'h1FFF_FFFF) begin errors++; $display("FAIL ties_max_val: got %0h want 1fffffff", max_val_a); end
        checks++; if (margin_a !== 30'd0) begin errors++; $display("FAIL ties_margin: got %0h want 0", margin_a); end
        consume();
    endtask

    task automatic test_extremes;
        frame_a(ext_s);
        checks++; if (predict_a !== 32'd1 || second_a !== 32'd2) begin errors++; $display("FAIL ext_idx: got %0d/%0d want 1/2", predict_a, second_a); end
        checks++; if (max_val_a !== 29'h0FFF_FFFF) begin errors++; $display("FAIL ext_max_val: got %0h want fffffff", max_val_a); end
        checks++; if (margin_a !== 30'h0FFF_FFFF) begin errors++; $display("FAIL ext_margin: got %0h want fffffff", margin_a); end
        consume();
        in_valid_c = 1'b1;
        in_data_c  = {DW'(-268435456), DW'(268435455)};
        @(posedge clk); #1;
        in_valid_c = 1'b0;
        checks++; if (out_valid_c !== 1'b1) begin errors++; $display("FAIL two_class_valid: got %b want 1", out_valid_c); end
        checks++; if (predict_c !== 32'd0 || second_c !== 32'd1) begin errors++; $display("FAIL two_class_idx: got %0d/%0d want 0/1", predict_c, second_c); end
        checks++; if (margin_c !== 30'h1FFF_FFFF) begin errors++; $display("FAIL two_class_margin: got %0h want 1fffffff", margin_c); end
        consume();
    endtask

    task automatic test_padding;
        in_valid_b = 1'b1;
        in_data_b = {DW'(2), DW'(1)};           @(posedge clk); #1;
        in_data_b = {DW'(9), DW'(3)};           @(posedge clk); #1;
        checks++; if (out_valid_b !== 1'b0) begin errors++; $display("FAIL pad_early_valid: got %b want 0", out_valid_b); end
        in_data_b = {DW'(32'h0FFF_FFFF), DW'(4)}; @(posedge clk); #1;
        in_valid_b = 1'b0;
        checks++; if (out_valid_b !== 1'b1) begin errors++; $display("FAIL pad_valid: got %b want 1", out_valid_b); end
        checks++; if (predict_b !== 32'd3 || second_b !== 32'd4) begin errors++; $display("FAIL pad_idx: got %0d/%0d want 3/4", predict_b, second_b); end
        checks++; if (max_val_b !== DW'(9) || margin_b !== 30'd5) begin errors++; $display("FAIL pad_vals: got %0h/%0h want 9/5", max_val_b, margin_b); end
        consume();
    endtask

    task automatic test_lanes1;
        in_valid_d = 1'b1;
        in_data_d = DW'(-10); @(posedge clk); #1;
        in_data_d = DW'(-20); @(posedge clk); #1;
        in_data_d = DW'(-30); @(posedge clk); #1;
        in_valid_d = 1'b0;
        checks++; if (out_valid_d !== 1'b1) begin errors++; $display("FAIL lane1_valid: got %b want 1", out_valid_d); end
        checks++; if (predict_d !== 32'd0 || second_d !== 32'd1) begin errors++; $display("FAIL lane1_idx: got %0d/%0d want 0/1", predict_d, second_d); end
        checks++; if (max_val_d !== DW'(-10) || margin_d !== 30'd10) begin errors++; $display("FAIL lane1_vals: got %0h/%0h want 1ffffff6/a", max_val_d, margin_d); end
        consume();
    endtask

    task automatic test_backpressure;
        int cycles;
        frame_a(neg_s);
        out_ready  = 1'b0;
        in_valid_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data_a = {DW'(1000 + i), DW'(2000 + i)};
            @(posedge clk); #1;
            checks++; if (in_ready_a !== 1'b0 || out_valid_a !== 1'b1) begin errors++; $display("FAIL bp_handshake: got ready=%b valid=%b want 0/1", in_ready_a, out_valid_a); end
            checks++; if (predict_a !== 32'd9 || second_a !== 32'd5 || max_val_a !== 29'h1FFF_FFFF || margin_a !== 30'd1) begin
                errors++; $display("FAIL bp_stable: got %0d/%0d/%0h/%0h want 9/5/1fffffff/1", predict_a, second_a, max_val_a, margin_a);
            end
        end
        in_data_a = {DW'(next_s[1]), DW'(next_s[0])};
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        cycles = 1;
        checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL bp_release: got %b want 0", out_valid_a); end
        for (int i = 0; i < 10; i += 2) begin
            in_data_a = {DW'(next_s[i+1]), DW'(next_s[i])};
            @(posedge clk); #1;
            cycles++;
        end
        in_valid_a = 1'b0;
        while (out_valid_a !== 1'b1 && cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
        end
        checks++; if (cycles !== 6) begin errors++; $display("FAIL bp_period: got %0d cycles want 6", cycles); end
        checks++; if (predict_a !== 32'd5 || second_a !== 32'd2) begin errors++; $display("FAIL bp_next_idx: got %0d/%0d want 5/2", predict_a, second_a); end
        checks++; if (max_val_a !== DW'(31) || margin_a !== 30'd1) begin errors++; $display("FAIL bp_next_vals: got %0h/%0h want 1f/1", max_val_a, margin_a); end
        consume();
    endtask

    task automatic test_clear;
        beat_a(1, 500);
        beat_a(2, 3);
        beat_a(4, 5);
        clear      = 1'b1;
        in_valid_a = 1'b1;
        in_data_a  = {DW'(600), DW'(600)};
        @(posedge clk); #1;
        clear      = 1'b0;
        in_valid_a = 1'b0;
        checks++; if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin errors++; $display("FAIL clear_state: got valid=%b ready=%b want 0/1", out_valid_a, in_ready_a); end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL clear_no_output: got %b want 0", out_valid_a); end
        frame_a(basic_s);
        checks++; if (out_valid_a !== 1'b1 || predict_a !== 32'd2 || second_a !== 32'd4) begin
            errors++; $display("FAIL clear_next_frame: got valid=%b %0d/%0d want 1 2/4", out_valid_a, predict_a, second_a);
        end
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL clear_in_hold: got %b want 0", out_valid_a); end
    endtask

    task automatic test_async_reset;
        frame_a(ties_s);
        #2;
        rst = 1'b0;
        #1;
        checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b want 0", out_valid_a); end
        checks++; if (predict_a !== 32'd0 || second_a !== 32'd0 || max_val_a !== '0 || margin_a !== '0) begin
            errors++; $display("FAIL areset_outputs: got %0d/%0d/%0h/%0h want all 0", predict_a, second_a, max_val_a, margin_a);
        end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        beat_a(7000, 7001);
        beat_a(7002, 7003);
        #2;
        rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL midframe_reset_valid: got %b want 0", out_valid_a); end
        frame_a(neg_s);
        checks++; if (out_valid_a !== 1'b1 || predict_a !== 32'd9 || second_a !== 32'd5) begin
            errors++; $display("FAIL midframe_reset_next: got valid=%b %0d/%0d want 1 9/5", out_valid_a, predict_a, second_a);
        end
        consume();
    endtask

    initial begin
        basic_s = '{5, -3, 100, 7, 100, 2, 0, -50, 99, 1};
        ties_s  = '{-1, -1, -1, -1, -1, -1, -1, -1, -1, -1};
        neg_s   = '{-7, -9, -8, -100, -3, -2, -50, -4, -6, -1};
        ext_s   = '{-268435456, 268435455, 0, 0, 0, 0, 0, 0, 0, 0};
        next_s  = '{10, -20, 30, 25, -5, 31, 0, 29, 1, 2};
        test_reset();
        test_basic();
        test_ties();
        test_extremes();
        test_padding();
        test_lanes1();
        test_backpressure();
        test_clear();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
